// File: rtl/single_port_ram_pkg.sv
// single_port_ram_pkg: default widths and the even-parity helper shared by RTL and bench.
package single_port_ram_pkg;
    localparam int DATA_WIDTH_DEF    = 8;
    localparam int ADDRESS_WIDTH_DEF = 8;
    // Data wider than 64 bits would need a wider argument; zero-extension leaves parity unchanged.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/single_port_ram_parity.sv
// single_port_ram_parity: even-parity generation on write and mismatch check on read.
// Only built when SINGLE_PORT_RAM_PARITY_EN is defined.
`ifdef SINGLE_PORT_RAM_PARITY_EN
module single_port_ram_parity
    import single_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  rd_par_i,
    input  logic                  rd_en_i,
    output logic                  wr_par_o,
    output logic                  err_o
);
    assign wr_par_o = even_parity(64'(din_i));
    assign err_o    = rd_en_i & (rd_par_i != even_parity(64'(rd_data_i)));
endmodule
`endif

// File: rtl/single_port_ram.sv
// single_port_ram: synchronous-write, combinational-read RAM with cs/we/oe and async clear.
// Define SINGLE_PORT_RAM_PARITY_EN to add per-word even parity and the parity_err output.
module single_port_ram
    import single_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cs,
    input  logic                     we,
    input  logic                     oe,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [DATA_WIDTH-1:0]    dout
`ifdef SINGLE_PORT_RAM_PARITY_EN
    ,
    output logic                     parity_err
`endif
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic                             wr_en;
    logic                             rd_en;

    assign wr_en = cs & we;
    // A write cycle never drives read data: write wins over oe.
    assign rd_en = cs & oe & ~we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_q <= '0;
        else if (wr_en) mem_q[address] <= din;
    end

    assign dout = rd_en ? mem_q[address] : '0;

`ifdef SINGLE_PORT_RAM_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic             wr_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= '0;
        else if (wr_en) par_q[address] <= wr_par;
    end

    single_port_ram_parity #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .din_i     (din),
        .rd_data_i (mem_q[address]),
        .rd_par_i  (par_q[address]),
        .rd_en_i   (rd_en),
        .wr_par_o  (wr_par),
        .err_o     (parity_err)
    );
`endif
endmodule

// File: tb/tb_single_port_ram.sv
// tb_single_port_ram: directed stimulus, per-cycle reference-model compare plus literal checks.
// Parity checks are compiled only when SINGLE_PORT_RAM_PARITY_EN is defined.
module tb_single_port_ram;
    import single_port_ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic       oe = 1'b0;
    logic [7:0] address = '0;
    logic [7:0] din = '0;
    logic [7:0] dout;
`ifdef SINGLE_PORT_RAM_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    bit corrupt = 1'b0;
    logic [7:0] model [256] = '{default: '0};

    single_port_ram dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cs      (cs),
        .we      (we),
        .oe      (oe),
        .address (address),
        .din     (din),
        .dout    (dout)
`ifdef SINGLE_PORT_RAM_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Reference memory: cleared whenever reset is low, written on qualifying edges.
    always @(negedge rst_n) for (int i = 0; i < 256; i++) model[i] = '0;
    always @(posedge clk) begin
        if (!rst_n) for (int i = 0; i < 256; i++) model[i] = '0;
        else if (cs && we) model[address] = din;
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!corrupt) begin
            check("model_dout", dout, (cs && oe && !we) ? model[address] : 8'd0);
`ifdef SINGLE_PORT_RAM_PARITY_EN
            check("model_parity_err", {7'd0, parity_err}, 8'd0);
`endif
        end
    end

    task automatic cyc(input logic c, input logic w, input logic o, input logic [7:0] a, input logic [7:0] d);
        @(posedge clk);
        #2;
        cs = c; we = w; oe = o; address = a; din = d;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(1, 0, 1, 0, 0);   check("rst_addr0", dout, 8'd0);
        cyc(1, 0, 1, 1, 0);   check("rst_addr1", dout, 8'd0);
        cyc(1, 0, 1, 2, 0);   check("rst_addr2", dout, 8'd0);
        cyc(1, 0, 1, 255, 0); check("rst_addr255", dout, 8'd0);
        cyc(1, 1, 0, 0, 145); check("write_no_out", dout, 8'd0);
        cyc(1, 1, 0, 1, 155);
        cyc(1, 1, 0, 2, 165);
        cyc(1, 0, 1, 0, 0);   check("read_addr0", dout, 8'd145);
        cyc(1, 0, 1, 1, 0);   check("read_addr1", dout, 8'd155);
        address = 8'd2;
        #1 check("read_addr2_async", dout, 8'd165);
        cyc(1, 0, 0, 3, 175);
        cyc(1, 0, 0, 3, 175);
        cyc(1, 0, 0, 3, 175);
        cyc(1, 0, 1, 3, 0);   check("no_we_blocked", dout, 8'd0);
        cyc(1, 0, 0, 0, 0);   check("oe_low_gate", dout, 8'd0);
        cyc(0, 0, 1, 0, 0);   check("cs_low_gate", dout, 8'd0);
        cyc(0, 1, 0, 0, 99);
        cyc(1, 0, 1, 0, 0);   check("cs_low_no_write", dout, 8'd145);
        cyc(1, 1, 1, 1, 77);  check("we_oe_write_wins", dout, 8'd0);
        cyc(1, 0, 1, 1, 0);   check("we_oe_updated", dout, 8'd77);
        cyc(1, 0, 1, 0, 0);   check("pre_reset_addr0", dout, 8'd145);
        rst_n = 1'b0;
        #1 check("async_reset_clear", dout, 8'd0);
        cyc(1, 1, 0, 1, 200);
        cyc(1, 0, 1, 1, 0);   check("write_in_reset_blocked", dout, 8'd0);
        rst_n = 1'b1;
        cyc(1, 0, 1, 2, 0);   check("post_reset_addr2", dout, 8'd0);
        cyc(1, 1, 0, 4, 42);
        cyc(1, 0, 1, 4, 0);   check("post_reset_write", dout, 8'd42);
`ifdef SINGLE_PORT_RAM_PARITY_EN
        check("parity_fn_0x91", {7'd0, even_parity(64'h91)}, 8'd1);
        cyc(1, 1, 0, 5, 8'h91);
        cyc(1, 0, 1, 5, 0);   check("par_clean_dout", dout, 8'h91);
        check("par_clean_err", {7'd0, parity_err}, 8'd0);
        corrupt = 1'b1;
        force dut.mem_q[5] = 8'h90;
        #1 check("par_flip_err", {7'd0, parity_err}, 8'd1);
        address = 8'd4;
        #1 check("par_other_word", {7'd0, parity_err}, 8'd0);
        release dut.mem_q[5];
`endif
        cyc(0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
